// File: rtl/e203_dtcm_mbank_pkg.sv
// Shared widths and parity helpers for the multi-bank DTCM controller.
// E203_DTCM_MBANK_PARITY_EN widens each bank with one even-parity bit per byte.
package e203_dtcm_mbank_pkg;

  function automatic int bw_f(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 0;
  endfunction

  function automatic int raw_f(input int aw, input int nbank);
    return aw - 2 - bw_f(nbank);
  endfunction

  function automatic int edw_f(input int dw);
`ifdef E203_DTCM_MBANK_PARITY_EN
    return dw + dw / 8;
`else
    return dw;
`endif
  endfunction

  function automatic int ew_f(input int dw);
`ifdef E203_DTCM_MBANK_PARITY_EN
    return 2 * (dw / 8);
`else
    return dw / 8;
`endif
  endfunction

  function automatic logic par_byte(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/e203_dtcm_mbank_rr_arbt.sv
// Round-robin arbiter: one-hot grant, pointer moves past the last winner.
module e203_dtcm_rr_arbt #(
  parameter int NPORT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  output logic [NPORT-1:0] gnt
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic          hit;

  always_comb begin
    gnt = '0;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (!hit && req[(int'(ptr) + k) % NPORT]) begin
        hit = 1'b1;
        gnt[(int'(ptr) + k) % NPORT] = 1'b1;
        sel = PW'((int'(ptr) + k) % NPORT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (hit)
      ptr <= PW'((int'(sel) + 1) % NPORT);
  end

endmodule

// File: rtl/e203_dtcm_mbank_ctrl.sv
// Multi-port, word-interleaved multi-bank DTCM controller.
// Optional per-byte parity via E203_DTCM_MBANK_PARITY_EN.
module e203_dtcm_mbank_ctrl
  import e203_dtcm_mbank_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int NBANK = 2,
  parameter int AW    = 16,
  parameter int DW    = 32,
  localparam int MW   = DW / 8,
  localparam int BW   = bw_f(NBANK),
  localparam int RAW  = raw_f(AW, NBANK),
  localparam int EDW  = edw_f(DW),
  localparam int EW   = ew_f(DW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     p_cmd_valid,
  output logic [NPORT-1:0]     p_cmd_ready,
  input  logic [NPORT-1:0]     p_cmd_read,
  input  logic [NPORT*AW-1:0]  p_cmd_addr,
  input  logic [NPORT*DW-1:0]  p_cmd_wdata,
  input  logic [NPORT*MW-1:0]  p_cmd_wmask,
  output logic [NPORT-1:0]     p_rsp_valid,
  input  logic [NPORT-1:0]     p_rsp_ready,
  output logic [NPORT-1:0]     p_rsp_err,
  output logic [NPORT*DW-1:0]  p_rsp_rdata,
  output logic [NBANK-1:0]     bank_cs,
  output logic [NBANK-1:0]     bank_we,
  output logic [NBANK*RAW-1:0] bank_addr,
  output logic [NBANK*EW-1:0]  bank_wem,
  output logic [NBANK*EDW-1:0] bank_din,
  input  logic [NBANK*EDW-1:0] bank_dout,
  output logic                 active
);

  localparam int BIW = (BW > 0) ? BW : 1;

  logic [BIW-1:0]   bsel   [NPORT];
  logic [RAW-1:0]   row    [NPORT];
  logic [EW-1:0]    wem_e  [NPORT];
  logic [EDW-1:0]   din_e  [NPORT];
  logic [NPORT-1:0] req    [NBANK];
  logic [NPORT-1:0] gnt    [NBANK];
  logic [NPORT-1:0] slot_free;

  logic [NPORT-1:0] rsp_valid_q;
  logic [NPORT-1:0] fresh_q;
  logic [NPORT-1:0] read_q;
  logic [NPORT-1:0] herr_q;
  logic [BIW-1:0]   rbank_q [NPORT];
  logic [DW-1:0]    hold_q  [NPORT];
  logic [DW-1:0]    live_d  [NPORT];
  logic [NPORT-1:0] live_err;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      bsel[i] = BIW'(p_cmd_addr[i*AW +: AW] >> 2) & BIW'(NBANK - 1);
      row[i]  = RAW'(p_cmd_addr[i*AW +: AW] >> (2 + BW));
`ifdef E203_DTCM_MBANK_PARITY_EN
      wem_e[i] = {p_cmd_wmask[i*MW +: MW], p_cmd_wmask[i*MW +: MW]};
      din_e[i] = {{MW{1'b0}}, p_cmd_wdata[i*DW +: DW]};
      for (int m = 0; m < MW; m++)
        din_e[i][DW+m] = par_byte(p_cmd_wdata[i*DW + m*8 +: 8]);
`else
      wem_e[i] = p_cmd_wmask[i*MW +: MW];
      din_e[i] = p_cmd_wdata[i*DW +: DW];
`endif
    end
  end

  // A port may issue only when its response slot drains this cycle.
  assign slot_free = ~rsp_valid_q | p_rsp_ready;

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      req[b] = '0;
      for (int i = 0; i < NPORT; i++)
        req[b][i] = !rst && p_cmd_valid[i] && slot_free[i]
                    && (int'(bsel[i]) == b);
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    e203_dtcm_rr_arbt #(.NPORT(NPORT)) u_arbt (
      .clk (clk),
      .rst (rst),
      .req (req[b]),
      .gnt (gnt[b])
    );
  end

  always_comb begin
    p_cmd_ready = '0;
    bank_cs     = '0;
    bank_we     = '0;
    bank_addr   = '0;
    bank_wem    = '0;
    bank_din    = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (gnt[b][i]) begin
          p_cmd_ready[i]        = 1'b1;
          bank_cs[b]            = 1'b1;
          bank_we[b]            = !p_cmd_read[i];
          bank_addr[b*RAW +: RAW] = row[i];
          bank_wem[b*EW +: EW]  = p_cmd_read[i] ? '0 : wem_e[i];
          bank_din[b*EDW +: EDW] = din_e[i];
        end
      end
    end
  end

  always_comb begin
    live_err = '0;
    for (int i = 0; i < NPORT; i++) begin
      live_d[i] = '0;
      if (read_q[i]) begin
        live_d[i] = bank_dout[int'(rbank_q[i])*EDW +: DW];
`ifdef E203_DTCM_MBANK_PARITY_EN
        for (int m = 0; m < MW; m++)
          if (par_byte(bank_dout[int'(rbank_q[i])*EDW + m*8 +: 8])
              != bank_dout[int'(rbank_q[i])*EDW + DW + m])
            live_err[i] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      fresh_q     <= '0;
      read_q      <= '0;
      herr_q      <= '0;
      for (int i = 0; i < NPORT; i++) begin
        rbank_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      fresh_q <= p_cmd_ready;
      for (int i = 0; i < NPORT; i++) begin
        if (p_cmd_ready[i]) begin
          rsp_valid_q[i] <= 1'b1;
          read_q[i]      <= p_cmd_read[i];
          rbank_q[i]     <= bsel[i];
        end else if (p_rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
        // SRAM output is only valid in the first cycle; park it here.
        if (rsp_valid_q[i] && fresh_q[i] && !p_rsp_ready[i]) begin
          hold_q[i] <= live_d[i];
          herr_q[i] <= live_err[i];
        end
      end
    end
  end

  always_comb begin
    p_rsp_valid = rsp_valid_q & {NPORT{!rst}};
    p_rsp_err   = '0;
    p_rsp_rdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      p_rsp_rdata[i*DW +: DW] = fresh_q[i] ? live_d[i] : hold_q[i];
`ifdef E203_DTCM_MBANK_PARITY_EN
      p_rsp_err[i] = p_rsp_valid[i]
                     && (fresh_q[i] ? live_err[i] : herr_q[i]);
`endif
    end
  end

  assign active = (|p_cmd_valid) || (|p_rsp_valid);

endmodule

// File: tb/tb_e203_dtcm_mbank_ctrl.sv
// Directed bench for e203_dtcm_mbank_ctrl with a behavioural SRAM per bank.
// Works with or without E203_DTCM_MBANK_PARITY_EN.
module tb_e203_dtcm_mbank_ctrl;
  import e203_dtcm_mbank_pkg::*;

  localparam int NPORT = 2;
  localparam int NBANK = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int RAW   = raw_f(AW, NBANK);
  localparam int EDW   = edw_f(DW);
  localparam int EW    = ew_f(DW);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NPORT-1:0]     p_cmd_valid;
  logic [NPORT-1:0]     p_cmd_ready;
  logic [NPORT-1:0]     p_cmd_read;
  logic [NPORT*AW-1:0]  p_cmd_addr;
  logic [NPORT*DW-1:0]  p_cmd_wdata;
  logic [NPORT*MW-1:0]  p_cmd_wmask;
  logic [NPORT-1:0]     p_rsp_valid;
  logic [NPORT-1:0]     p_rsp_ready;
  logic [NPORT-1:0]     p_rsp_err;
  logic [NPORT*DW-1:0]  p_rsp_rdata;
  logic [NBANK-1:0]     bank_cs;
  logic [NBANK-1:0]     bank_we;
  logic [NBANK*RAW-1:0] bank_addr;
  logic [NBANK*EW-1:0]  bank_wem;
  logic [NBANK*EDW-1:0] bank_din;
  logic [NBANK*EDW-1:0] bank_dout;
  logic                 active;

  logic [EDW-1:0] mem    [NBANK][1<<RAW];
  logic [EDW-1:0] dout_q [NBANK];
  logic [EDW-1:0] wtmp;
  logic [EDW-1:0] flip;
  logic           exp_err;

  int n_pass = 0;
  int n_chk  = 0;

  e203_dtcm_mbank_ctrl #(
    .NPORT(NPORT), .NBANK(NBANK), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .p_cmd_valid(p_cmd_valid), .p_cmd_ready(p_cmd_ready),
    .p_cmd_read(p_cmd_read), .p_cmd_addr(p_cmd_addr),
    .p_cmd_wdata(p_cmd_wdata), .p_cmd_wmask(p_cmd_wmask),
    .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready),
    .p_rsp_err(p_rsp_err), .p_rsp_rdata(p_rsp_rdata),
    .bank_cs(bank_cs), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wem(bank_wem), .bank_din(bank_din), .bank_dout(bank_dout),
    .active(active)
  );

  always #5 clk = ~clk;

  initial for (int b = 0; b < NBANK; b++) dout_q[b] = '0;

  // Synchronous SRAM: byte-masked write, registered read data.
  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (bank_cs[b]) begin
        if (bank_we[b]) begin
          wtmp = mem[b][bank_addr[b*RAW +: RAW]];
          for (int k = 0; k < EDW; k++) begin
            if (k < DW ? bank_wem[b*EW + k/8] : bank_wem[b*EW + MW + k - DW])
              wtmp[k] = bank_din[b*EDW + k];
          end
          mem[b][bank_addr[b*RAW +: RAW]] <= wtmp;
        end else begin
          dout_q[b] <= mem[b][bank_addr[b*RAW +: RAW]];
        end
      end
    end
  end

  always_comb begin
    bank_dout = '0;
    for (int b = 0; b < NBANK; b++) bank_dout[b*EDW +: EDW] = dout_q[b];
    bank_dout[EDW-1:0] = dout_q[0] ^ flip;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cmd(input int p, input logic v, input logic rd,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [MW-1:0] m);
    p_cmd_valid[p]          = v;
    p_cmd_read[p]           = rd;
    p_cmd_addr[p*AW +: AW]  = a;
    p_cmd_wdata[p*DW +: DW] = d;
    p_cmd_wmask[p*MW +: MW] = m;
  endtask

  task automatic idle();
    cmd(0, 0, 0, '0, '0, '0);
    cmd(1, 0, 0, '0, '0, '0);
  endtask

  // Drive point is 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flip = '0;
`ifdef E203_DTCM_MBANK_PARITY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    p_rsp_ready = 2'b11;
    p_cmd_valid = '0; p_cmd_read = '0; p_cmd_addr = '0;
    p_cmd_wdata = '0; p_cmd_wmask = '0;
    cmd(0, 1, 1, 16'h0, '0, '0);
    cmd(1, 1, 1, 16'h4, '0, '0);
    tick(); tick();
    #1;
    check("rst_ready", 64'(p_cmd_ready), 64'h0);
    check("rst_cs", 64'(bank_cs), 64'h0);
    check("rst_rsp_valid", 64'(p_rsp_valid), 64'h0);
    check("rst_err", 64'(p_rsp_err), 64'h0);
    check("rst_rdata", 64'(p_rsp_rdata), 64'h0);

    // Write then back-to-back read of word 0.
    tick(); rst = 1'b0; idle();
    cmd(0, 1, 0, 16'h0, 32'hA5A5A5A5, 4'hF);
    #1;
    check("wr_ready", 64'(p_cmd_ready), 64'h1);
    check("wr_cs", 64'(bank_cs), 64'h1);
    check("wr_we", 64'(bank_we), 64'h1);
    check("wr_wem", 64'(bank_wem[MW-1:0]), 64'hF);
    check("active", 64'(active), 64'h1);
    tick(); cmd(0, 1, 1, 16'h0, '0, '0);
    #1;
    check("wr_rsp_valid", 64'(p_rsp_valid), 64'h1);
    check("wr_rsp_rdata", 64'(p_rsp_rdata[31:0]), 64'h0);
    check("rd_b2b_ready", 64'(p_cmd_ready), 64'h1);
    check("rd_we", 64'(bank_we), 64'h0);
    tick(); idle();
    #1;
    check("rd_rsp_valid", 64'(p_rsp_valid), 64'h1);
    check("rd_rdata", 64'(p_rsp_rdata[31:0]), 64'hA5A5A5A5);
    check("rd_err", 64'(p_rsp_err), 64'h0);

    // Port1 writes bank1 row 0 and row 3.
    tick(); cmd(1, 1, 0, 16'h4, 32'h12345678, 4'hF);
    #1;
    check("p1_wr_cs", 64'(bank_cs), 64'h2);
    tick(); cmd(1, 1, 0, 16'h1C, 32'hDEADBEEF, 4'hF);
    #1;
    check("p1_row3", 64'(bank_addr[RAW +: RAW]), 64'h3);
    tick(); idle();

    // Parallel reads on both banks.
    tick(); cmd(0, 1, 1, 16'h0, '0, '0); cmd(1, 1, 1, 16'h4, '0, '0);
    #1;
    check("par_ready", 64'(p_cmd_ready), 64'h3);
    check("par_cs", 64'(bank_cs), 64'h3);
    tick(); cmd(0, 0, 0, '0, '0, '0); cmd(1, 1, 1, 16'h1C, '0, '0);
    #1;
    check("par_rsp_valid", 64'(p_rsp_valid), 64'h3);
    check("par_rdata0", 64'(p_rsp_rdata[31:0]), 64'hA5A5A5A5);
    check("par_rdata1", 64'(p_rsp_rdata[63:32]), 64'h12345678);
    tick(); idle();
    #1;
    check("row3_rdata", 64'(p_rsp_rdata[63:32]), 64'hDEADBEEF);

    // Port0 read leaves bank0 pointer at 1; reset mid-response.
    tick(); cmd(0, 1, 1, 16'h0, '0, '0);
    tick(); idle(); rst = 1'b1;
    cmd(0, 1, 1, 16'h8, '0, '0);
    #1;
    check("rst_mid_valid", 64'(p_rsp_valid), 64'h0);
    check("rst_mid_cs", 64'(bank_cs), 64'h0);
    tick(); idle();
    #1;
    check("rst_after_valid", 64'(p_rsp_valid), 64'h0);

    // Both ports hammer bank0: grants alternate from port 0.
    rst = 1'b0;
    cmd(0, 1, 1, 16'h0, '0, '0); cmd(1, 1, 1, 16'h8, '0, '0);
    #1;
    check("rr_g0", 64'(p_cmd_ready), 64'h1);
    tick(); #1;
    check("rr_g1", 64'(p_cmd_ready), 64'h2);
    tick(); #1;
    check("rr_g2", 64'(p_cmd_ready), 64'h1);
    tick(); #1;
    check("rr_g3", 64'(p_cmd_ready), 64'h2);
    tick(); idle();
    tick(); tick();

    // Stalled read response must hold while bank0 keeps moving.
    p_rsp_ready = 2'b10;
    cmd(0, 1, 1, 16'h0, '0, '0);
    #1;
    check("st_s0_ready", 64'(p_cmd_ready), 64'h1);
    tick(); cmd(0, 1, 1, 16'h8, '0, '0);
    cmd(1, 1, 0, 16'h8, 32'h11111111, 4'hF);
    #1;
    check("st_s1_rdata", 64'(p_rsp_rdata[31:0]), 64'hA5A5A5A5);
    check("st_s1_ready", 64'(p_cmd_ready), 64'h2);
    tick(); cmd(1, 1, 1, 16'h8, '0, '0);
    #1;
    check("st_s2_rdata", 64'(p_rsp_rdata[31:0]), 64'hA5A5A5A5);
    check("st_s2_ready", 64'(p_cmd_ready), 64'h2);
    tick(); cmd(1, 0, 0, '0, '0, '0);
    #1;
    check("st_s3_rdata", 64'(p_rsp_rdata[31:0]), 64'hA5A5A5A5);
    check("st_s3_ready", 64'(p_cmd_ready), 64'h0);
    check("st_s3_rdata1", 64'(p_rsp_rdata[63:32]), 64'h11111111);
    p_rsp_ready = 2'b11;
    #1;
    check("st_s4_ready", 64'(p_cmd_ready), 64'h1);
    check("st_s4_valid", 64'(p_rsp_valid[0]), 64'h1);
    tick(); idle();
    #1;
    check("st_s5_rdata", 64'(p_rsp_rdata[31:0]), 64'h11111111);

    // Corrupt bit 0 of the SRAM word on the read of 0x8.
    tick(); cmd(0, 1, 1, 16'h8, '0, '0);
    tick(); idle(); flip = EDW'(1);
    #1;
    check("par_err", 64'(p_rsp_err[0]), 64'(exp_err));
    check("par_rdata", 64'(p_rsp_rdata[31:0]), 64'h11111110);
    tick(); flip = '0;
    tick();
    #1;
    check("idle_active", 64'(active), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
